// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch unit
package if_pkg;

  localparam int IF_XLEN = 32;
  localparam logic [IF_XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_SEL_NEXT = 2'd0,
    PC_SEL_BR   = 2'd1,
    PC_SEL_JALR = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - fetch buffer: DEPTH storage entries behind a registered head
// An empty buffer bypasses pushes straight into the head so a word shows one cycle after rvalid.
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [IF_XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  fetch_entry_t            push_data_i,
  input  logic                    pop_i,
  output logic                    out_valid_o,
  output fetch_entry_t            out_data_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           out_valid_q, out_valid_d;
  fetch_entry_t   out_q, out_d;
  logic           out_free;
  logic           mem_wr;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    mem_wr      = 1'b0;
    out_free    = ~out_valid_q | pop_i;
    if (flush_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_free) begin
        if (count_q != '0) begin
          out_d       = mem_q[rd_ptr_q];
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + AW'(1);
          count_d     = count_q - (AW+1)'(1);
        end else if (push_i) begin
          out_d       = push_data_i;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      // Anything not bypassed into the head queues behind it to keep order.
      if (push_i && !(out_free && count_q == '0)) begin
        mem_wr   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_d + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '{pc: RESET_PC, inst: INST_NOP};
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;
  assign count_o     = count_q;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch unit: PC, IRAM requests, response buffering, redirects
module if_fetch
  import if_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic            iram_rd_req_o,
  output logic [XLEN-1:0] iram_rd_addr_o,
  input  logic            iram_rd_gnt_i,
  input  logic            iram_rd_rvalid_i,
  input  logic [XLEN-1:0] iram_rd_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_data_o,
  output logic [XLEN-1:0] pc_data_o,
  input  logic            pc_wr_en_i,
  input  logic [1:0]      pc_wr_sel_i,
  input  logic [XLEN-1:0] imm_data_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            pc_misalign_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] trk_pc_q [FIFO_DEPTH];
  logic [AW-1:0]   trk_wr_q, trk_wr_d;
  logic [AW-1:0]   trk_rd_q, trk_rd_d;

  logic [CW-1:0]   fifo_count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            can_req, gnt_acc, fire, redirect, push;
  pc_sel_e         sel;
  logic [XLEN-1:0] pc_seq, target_raw, target;

  // Storage occupancy plus in-flight reads bounds requests, so a response always has a slot.
  assign can_req        = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_W;
  assign iram_rd_req_o  = rst_n_i & can_req;
  assign iram_rd_addr_o = fetch_pc_q;
  assign gnt_acc        = iram_rd_req_o & iram_rd_gnt_i;
  assign fire           = inst_valid_o & inst_ready_i & pc_wr_en_i;
  assign sel            = pc_sel_e'(pc_wr_sel_i);

  always_comb begin
    pc_seq = pc_data_o + XLEN'(4);
    case (sel)
      PC_SEL_BR:   target_raw = pc_data_o + imm_data_i;
      PC_SEL_JALR: target_raw = alu_data_i & ~XLEN'(1);
      default:     target_raw = pc_seq;
    endcase
    target = target_raw;
    if (target_raw[1]) begin
      target[1:0] = 2'b00;
    end
  end

  assign redirect   = fire & (target != pc_seq);
  assign push       = iram_rd_rvalid_i & (discard_q == '0) & ~redirect;
  assign push_entry = '{pc: trk_pc_q[trk_rd_q], inst: iram_rd_data_i};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(gnt_acc) - CW'(iram_rd_rvalid_i);
    discard_d     = discard_q;
    misalign_d    = fire & target_raw[1];
    trk_wr_d      = trk_wr_q + AW'(gnt_acc);
    trk_rd_d      = trk_rd_q + AW'(iram_rd_rvalid_i);
    if (redirect) begin
      fetch_pc_d = target;
      discard_d  = outstanding_d;
    end else begin
      if (gnt_acc) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (iram_rd_rvalid_i && discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  // Tracker entries are consumed in response order, including words later discarded.
  always_ff @(posedge clk_i) begin
    if (gnt_acc) begin
      trk_pc_q[trk_wr_q] <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      misalign_q    <= 1'b0;
      trk_wr_q      <= '0;
      trk_rd_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      misalign_q    <= misalign_d;
      trk_wr_q      <= trk_wr_d;
      trk_rd_q      <= trk_rd_d;
    end
  end

  if_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (fire),
    .out_valid_o (inst_valid_o),
    .out_data_o  (head),
    .count_o     (fifo_count)
  );

  assign inst_data_o   = head.inst;
  assign pc_data_o     = head.pc;
  assign pc_misalign_o = misalign_q;

endmodule
